// File: rtl/crom_pixel_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : crom_pixel_serializer
//  Purpose  : Turns 64-bit planar C-ROM sprite-line words into a 4bpp pixel
//             stream, one pixel per pix_ce. A two-entry word buffer (shift +
//             holding) hides SDRAM burst latency from the line renderer.
//             Horizontal flip is latched per word; overflow/underrun are
//             sticky debug flags cleared by flush or reset.
//  Ports    : CLK        core clock, rising edge
//             nRESET     asynchronous active-low reset
//             CR_DOUBLE  C-ROM word, plane p = CR_DOUBLE[16p+15:16p]
//             cr_load    strobe: CR_DOUBLE / cr_flip valid this cycle
//             cr_flip    horizontal flip for the word being loaded
//             cr_ready   buffer can accept a word (not both entries full)
//             pix_ce     pixel clock enable: emit next pixel
//             flush      synchronous line-start flush
//             PIXEL      palette index of emitted pixel (registered)
//             pix_valid  PIXEL valid this cycle (registered)
//             pix_opaque PIXEL != 0 (registered, 0 when pix_valid = 0)
//             overflow   sticky: cr_load while cr_ready = 0
//             underrun   sticky: pix_ce while shift entry empty
//  Revision : 1.0 - initial release
// ============================================================================
module crom_pixel_serializer #(
    parameter int PIX_PER_WORD = 16,
    parameter int BPP          = 4
) (
    input  logic                          CLK,
    input  logic                          nRESET,
    input  logic [PIX_PER_WORD*BPP-1:0]   CR_DOUBLE,
    input  logic                          cr_load,
    input  logic                          cr_flip,
    output logic                          cr_ready,
    input  logic                          pix_ce,
    input  logic                          flush,
    output logic [BPP-1:0]                PIXEL,
    output logic                          pix_valid,
    output logic                          pix_opaque,
    output logic                          overflow,
    output logic                          underrun
);

    localparam int                c_WORD_W   = PIX_PER_WORD * BPP;
    localparam int                c_IDX_W    = $clog2(PIX_PER_WORD);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(PIX_PER_WORD - 1);

    logic [c_WORD_W-1:0] r_shift_word;
    logic                r_shift_flip;
    logic                r_shift_valid;
    logic [c_WORD_W-1:0] r_hold_word;
    logic                r_hold_flip;
    logic                r_hold_valid;
    logic [c_IDX_W-1:0]  r_idx;

    logic [c_IDX_W-1:0]  w_bit_pos;
    logic [BPP-1:0]      w_pix;
    logic                w_emit;
    logic                w_last;
    logic                w_load;
    logic                w_load_to_shift;

    // Ready is deliberately not look-ahead: a word arriving while both
    // entries are full is dropped even if the shift word is finishing.
    assign cr_ready = ~(r_shift_valid & r_hold_valid);

    assign w_emit = pix_ce & r_shift_valid;
    assign w_last = w_emit & (r_idx == c_LAST_IDX);
    assign w_load = cr_load & cr_ready;

    // New word goes straight to shift when shift is idle, or when shift is
    // retiring its last pixel with nothing waiting behind it (no-gap case).
    assign w_load_to_shift = ~r_shift_valid | (w_last & ~r_hold_valid);

    // Unflipped words emit MSB first; flipped words emit LSB first.
    assign w_bit_pos = r_shift_flip ? r_idx : (c_LAST_IDX - r_idx);

    generate
        for (genvar g = 0; g < BPP; g++) begin : g_plane
            assign w_pix[g] = r_shift_word[g*PIX_PER_WORD + int'(w_bit_pos)];
        end
    endgenerate

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_shift_word  <= '0;
            r_shift_flip  <= 1'b0;
            r_shift_valid <= 1'b0;
            r_hold_word   <= '0;
            r_hold_flip   <= 1'b0;
            r_hold_valid  <= 1'b0;
            r_idx         <= '0;
            PIXEL         <= '0;
            pix_valid     <= 1'b0;
            pix_opaque    <= 1'b0;
            overflow      <= 1'b0;
            underrun      <= 1'b0;
        end else if (flush) begin
            // Line start: drop everything, including any same-cycle load.
            r_shift_valid <= 1'b0;
            r_hold_valid  <= 1'b0;
            r_idx         <= '0;
            PIXEL         <= '0;
            pix_valid     <= 1'b0;
            pix_opaque    <= 1'b0;
            overflow      <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            // Pixel output stage
            if (pix_ce) begin
                if (r_shift_valid) begin
                    PIXEL      <= w_pix;
                    pix_valid  <= 1'b1;
                    pix_opaque <= |w_pix;
                end else begin
                    PIXEL      <= '0;
                    pix_valid  <= 1'b0;
                    pix_opaque <= 1'b0;
                    underrun   <= 1'b1;
                end
            end else begin
                pix_valid  <= 1'b0;
                pix_opaque <= 1'b0;
            end

            // Word advance: holding (possibly empty) moves into shift
            if (w_last) begin
                r_shift_word  <= r_hold_word;
                r_shift_flip  <= r_hold_flip;
                r_shift_valid <= r_hold_valid;
                r_hold_valid  <= 1'b0;
                r_idx         <= '0;
            end else if (w_emit) begin
                r_idx <= r_idx + 1'b1;
            end

            // Load overrides the advance when it targets the shift entry
            if (w_load) begin
                if (w_load_to_shift) begin
                    r_shift_word  <= CR_DOUBLE;
                    r_shift_flip  <= cr_flip;
                    r_shift_valid <= 1'b1;
                    r_idx         <= '0;
                end else begin
                    r_hold_word   <= CR_DOUBLE;
                    r_hold_flip   <= cr_flip;
                    r_hold_valid  <= 1'b1;
                end
            end

            if (cr_load && !cr_ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_crom_pixel_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_crom_pixel_serializer
//  Purpose  : Scoreboard bench for crom_pixel_serializer. The reference model
//             holds the buffered pixels as a flat queue; words in the buffer
//             are derived from its length. Expected pixels are queued at
//             stimulus time and popped by an independent output monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_crom_pixel_serializer;

    logic        CLK;
    logic        nRESET;
    logic [63:0] CR_DOUBLE;
    logic        cr_load;
    logic        cr_flip;
    logic        cr_ready;
    logic        pix_ce;
    logic        flush;
    logic [3:0]  PIXEL;
    logic        pix_valid;
    logic        pix_opaque;
    logic        overflow;
    logic        underrun;

    crom_pixel_serializer #(.PIX_PER_WORD(16), .BPP(4)) dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .CR_DOUBLE  (CR_DOUBLE),
        .cr_load    (cr_load),
        .cr_flip    (cr_flip),
        .cr_ready   (cr_ready),
        .pix_ce     (pix_ce),
        .flush      (flush),
        .PIXEL      (PIXEL),
        .pix_valid  (pix_valid),
        .pix_opaque (pix_opaque),
        .overflow   (overflow),
        .underrun   (underrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [3:0] pq[$];     // pixels still to be emitted, in order
    logic [3:0] sb[$];     // expected pixels awaiting the monitor
    bit         m_ovf;
    bit         m_udr;
    bit         m_valid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] pixel_of(input logic [63:0] w, input bit f, input int k);
        logic [3:0] r;
        int pos;
        pos = f ? k : 15 - k;
        for (int b = 0; b < 4; b++) r[b] = w[16*b + pos];
        return r;
    endfunction

    function automatic int words_held();
        return (pq.size() + 15) / 16;
    endfunction

    // One clock of stimulus; called at posedge+1, returns at next posedge+1.
    task automatic step(input bit ld, input logic [63:0] w, input bit fl,
                        input bit ce, input bit fsh);
        bit rdy;
        CR_DOUBLE = w;
        cr_load   = ld;
        cr_flip   = fl;
        pix_ce    = ce;
        flush     = fsh;
        rdy = (words_held() < 2);
        chk("cr_ready", cr_ready, rdy);
        if (fsh) begin
            pq.delete();
            m_ovf   = 0;
            m_udr   = 0;
            m_valid = 0;
        end else begin
            if (ce) begin
                if (pq.size() > 0) begin
                    sb.push_back(pq.pop_front());
                    m_valid = 1;
                end else begin
                    m_udr   = 1;
                    m_valid = 0;
                end
            end else begin
                m_valid = 0;
            end
            if (ld) begin
                if (rdy) for (int k = 0; k < 16; k++) pq.push_back(pixel_of(w, fl, k));
                else m_ovf = 1;
            end
        end
        @(posedge CLK);
        #1;
        chk("pix_valid", pix_valid, m_valid);
        chk("overflow", overflow, m_ovf);
        chk("underrun", underrun, m_udr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 64'h0, 0, 0, 0);
    endtask

    task automatic ce_n(input int n);
        for (int i = 0; i < n; i++) step(0, 64'h0, 0, 1, 0);
    endtask

    // Output monitor: consumes one expected pixel per valid output
    always @(negedge CLK) begin
        if (nRESET) begin
            if (pix_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pixel", 1, 0);
                end else begin
                    logic [3:0] p;
                    p = sb.pop_front();
                    chk("PIXEL", PIXEL, p);
                    chk("pix_opaque", pix_opaque, p != 4'd0);
                end
            end else begin
                chk("pix_opaque_idle", pix_opaque, 0);
            end
        end
    end

    task automatic model_reset();
        pq.delete();
        sb.delete();
        m_ovf   = 0;
        m_udr   = 0;
        m_valid = 0;
    endtask

    logic [63:0] w_a, w_b, w_c;

    initial begin
        nRESET    = 1'b0;
        CR_DOUBLE = '0;
        cr_load   = 0;
        cr_flip   = 0;
        pix_ce    = 0;
        flush     = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_PIXEL", PIXEL, 0);
        chk("rst_valid", pix_valid, 0);
        chk("rst_ready", cr_ready, 1);
        nRESET = 1'b1;

        // Single pixel at each edge of the word
        step(1, {48'h0, 16'h8001}, 0, 0, 0);
        ce_n(16);
        idle(2);

        // Flipped word: 9 then 8
        step(1, {16'hFFFF, 16'h0000, 16'h0000, 16'h00FF}, 1, 0, 0);
        ce_n(16);
        idle(1);

        // Three loads with no pix_ce: third is dropped, then underrun
        w_a = {$urandom, $urandom};
        w_b = {$urandom, $urandom};
        w_c = {$urandom, $urandom};
        step(1, w_a, 0, 0, 0);
        step(1, w_b, 1, 0, 0);
        step(1, w_c, 0, 0, 0);
        chk("ovf_sticky", overflow, 1);
        ce_n(33);
        chk("udr_sticky", underrun, 1);
        step(0, 64'h0, 0, 0, 1);   // flush clears flags

        // Load coincident with last pixel: no gap, no overflow
        step(1, w_a, 0, 0, 0);
        ce_n(15);
        step(1, w_b, 0, 1, 0);
        ce_n(17);
        idle(1);

        // Mid-word flush with a simultaneous load
        step(1, w_c, 1, 0, 0);
        ce_n(5);
        step(1, w_a, 0, 1, 1);
        step(0, 64'h0, 0, 1, 0);
        chk("flush_udr", underrun, 1);
        idle(1);

        // Reset mid-stream
        step(1, w_b, 0, 0, 0);
        ce_n(6);
        step(0, 64'h0, 0, 1, 0);
        #2 nRESET = 1'b0;
        #1;
        chk("amid_PIXEL", PIXEL, 0);
        chk("amid_valid", pix_valid, 0);
        chk("amid_opaque", pix_opaque, 0);
        chk("amid_ready", cr_ready, 1);
        model_reset();
        @(posedge CLK);
        #1;
        chk("arst_PIXEL", PIXEL, 0);
        chk("arst_valid", pix_valid, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_udr", underrun, 0);
        chk("arst_ready", cr_ready, 1);
        nRESET = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 12,
                 {$urandom, $urandom},
                 $urandom_range(0, 1),
                 $urandom_range(0, 99) < 80,
                 $urandom_range(0, 199) == 0);
        end

        // Drain and confirm every expected pixel was seen
        for (int i = 0; i < 40 && pq.size() > 0; i++) step(0, 64'h0, 0, 1, 0);
        idle(2);
        chk("model_drained", pq.size(), 0);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
